arb_burst_mux: RTL and testbench
================================

# arb_burst_mux

Downstream consumer of the 4-way round-robin arbiter's one-hot `grant`. It samples a grant while idle and locks onto that requester. It then steers that requester's data onto a single shared output stream as a fixed-length burst with valid/ready handshake, and returns per-requester beat acknowledges. Grants arriving mid-burst are ignored; unserved requesters keep requesting and are picked up on a later idle cycle.

## Interface
- `DATA_W`, default 8: width of each requester data word and of `out_data`.
- `BURST_LEN`, default 4: beats per burst, minimum 1.

- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-high.
- `grant`  input  4  one-hot grant from the arbiter; bit i selects requester i.
- `req_data`  input  4*DATA_W  requester i word on bits [i*DATA_W +: DATA_W].
- `req_ack`  output  4  bit owner high for each accepted beat.
- `req_last`  output  4  bit owner high with the final beat's ack.
- `out_valid`  output  1  shared stream valid.
- `out_ready`  input  1  shared stream ready.
- `out_data`  output  DATA_W  shared stream data.
- `out_id`  output  2  index of the locked requester.
- `out_last`  output  1  final beat of the burst.
- `err_grant`  output  1  sticky; a multi-hot grant was seen while idle.

## Operation
- States: IDLE, XFER.
- **IDLE:**
  - `out_valid` is 0.
  - If `grant` is exactly one-hot: `owner` <= index, `beat` <= 0, go to XFER.
  - If `grant` == 0: stay in IDLE.
  - If `grant` is multi-hot: stay in IDLE, set `err_grant`, and lock nothing.
- **XFER:**
  - `out_valid` is 1.
  - `out_data` = `req_data[owner]`, combinational from the live input.
  - `out_id` = `owner`.
  - `out_last` = (`beat` == BURST_LEN-1).
- **Handshake:** a beat transfers when `out_valid` and `out_ready` are both high.
  - `req_ack[owner]` = handshake, combinational.
  - `req_last[owner]` = handshake & `out_last`.
  - All other ack and last bits are 0.
- **Beat counter:** on a handshake, `beat` increments. On the handshake where `out_last` is set, the state returns to IDLE and `beat` clears.
- **Back-pressure:** while `out_ready` is 0, state, `beat`, `owner` and `out_id` hold. `out_data` follows `req_data[owner]`, and the requester must hold its word until acked.
- **Grants during XFER:** ignored entirely; they never change `owner` and never set `err_grant`.
- **Counter width:** `beat` is max(1, $clog2(BURST_LEN)) bits and never exceeds BURST_LEN-1.
- **BURST_LEN = 1:** `out_last` is constantly 1 in XFER, giving one beat per grant.
- **`err_grant`:** cleared only by reset.

## Timing
- **Reset values:**
  - State: IDLE.
  - `owner` = 0, `beat` = 0, `err_grant` = 0.
  - Outputs `out_valid`, `out_last`, `out_id`, `req_ack`, `req_last` are all 0.
  - `out_data` = 0 while IDLE.
- **Grant to stream latency:** a one-hot grant sampled at the edge ending cycle N gives `out_valid` = 1 in cycle N+1.
- **Throughput:** one beat per cycle while `out_ready` is held high. A burst takes BURST_LEN cycles in XFER.
- **Inter-burst gap:** final handshake in cycle M, IDLE in cycle M+1, earliest next `out_valid` in cycle M+2. The minimum is one idle cycle between bursts.
- **Same-cycle acks:** `req_ack` and `req_last` are asserted in the same cycle as the handshake.
- **Reset mid-burst:** asynchronous abort to IDLE with no further ack. A partially sent burst is not completed.
- **Simultaneous events:** a grant in the cycle of the final handshake is ignored, because the block is still in XFER. The grant is next sampled in cycle M+1.

## Structure
- **Shared package `arb_pkg`:**
  - State enum with IDLE = 1'b0 and XFER = 1'b1.
  - `NUM_REQ` = 4.
  - `ID_W` = 2.
  - Function `onehot_is_valid`.
- **Sub-module `onehot_to_index`:** 4-bit one-hot in; 2-bit index out plus a `valid` flag, where `valid` means exactly one bit is set. This sub-module is natural and is reused by other arbiter consumers.
- **Top level:** FSM, beat counter, owner register, data mux and ack decode.

## Test plan
- **Reset:** assert reset mid-XFER with BURST_LEN = 4 and `beat` = 2 -> immediately `out_valid` = 0, `req_ack` = 0, `err_grant` = 0. After release the block is IDLE.
- **Single burst, no stall:**
  - Stimulus: `grant` = 4'b0100 in IDLE, `out_ready` held at 1, `req_data[2]` stepping 8'hA0..8'hA3.
  - Cycle N+1: `out_valid` rises.
  - Cycles N+1..N+4: four beats A0..A3 with `out_id` = 2 and `req_ack` = 4'b0100 each cycle.
  - Last beat: `out_last` and `req_last` = 4'b0100.
  - Cycle N+5: IDLE.
- **Back-pressure:** `out_ready` = 0 for 3 cycles after the first beat -> `beat`, `out_id` and `out_last` hold, `req_ack` = 0 during the stall, and the burst still totals exactly 4 handshakes.
- **Mid-burst grant:** `grant` cycles 4'b0001, 4'b0010, 4'b1000 during requester 2's burst -> `out_id` stays 2 and `err_grant` stays 0. The next burst starts from the grant present in the first IDLE cycle.
- **Illegal grant:** `grant` = 4'b0110 in IDLE -> no XFER and `err_grant` = 1. `err_grant` stays 1 after a later legal burst and clears only on reset.
- **BURST_LEN = 1 build:** back-to-back grants 4'b0001 then 4'b1000 -> single-beat bursts with `out_last` = 1 and `req_last` equal to the owner bit. Consecutive `out_valid` pulses are separated by exactly one idle cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for consumers of the 4-way arbiter grant.
// Used by the burst mux and the one-hot decoder.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  function automatic logic onehot_is_valid(
    input logic [NUM_REQ-1:0] v
  );
    return (v != '0) &&
           ((v & (v - NUM_REQ'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// One-hot grant to binary index; valid only when exactly one bit is set.
// Index is don't-care (OR-encoded) for zero or multi-hot inputs.
module onehot_to_index
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    index,
  output logic               valid
);

  assign index = {onehot[3] | onehot[2],
                  onehot[3] | onehot[1]};

  assign valid = onehot_is_valid(onehot);

endmodule

// File: rtl/arb_burst_mux.sv
// Locks onto a one-hot grant while idle and streams a fixed-length
// burst of that requester's data with valid/ready and per-requester acks.
module arb_burst_mux
  import arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  output logic                      err_grant
);

  localparam int BEAT_W =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [ID_W-1:0]   g_idx;
  logic              g_ok;
  logic              xfer;
  logic              hs;
  logic [DATA_W-1:0] data_mux;

  onehot_to_index u_dec (
    .onehot (grant),
    .index  (g_idx),
    .valid  (g_ok)
  );

  assign xfer = (state_q == XFER);
  assign hs   = xfer & out_ready;

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        data_mux = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = xfer;
  assign out_data  = xfer ? data_mux : '0;
  assign out_id    = xfer ? owner_q : '0;
  assign out_last  = xfer && (beat_q == LAST_BEAT);
  assign err_grant = err_q;

  assign req_ack  = hs ? (NUM_REQ'(1) << owner_q) : '0;
  assign req_last = out_last ? req_ack : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (g_ok) begin
          owner_d = g_idx;
          beat_d  = '0;
          state_d = XFER;
        end else if (grant != '0) begin
          err_d = 1'b1;
        end
      end
      XFER: begin
        if (hs) begin
          if (out_last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_arb_burst_mux.sv
// Directed bench for arb_burst_mux: a BURST_LEN=4 instance and a
// BURST_LEN=1 instance sharing clock and reset.
module tb_arb_burst_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  grant = '0;
  logic [31:0] req_data = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  req_ack, req_last;
  logic        out_valid, out_last, err_grant;
  logic [7:0]  out_data;
  logic [1:0]  out_id;

  logic [3:0]  g1 = '0;
  logic [31:0] d1 = '0;
  logic        r1 = 1'b1;
  logic [3:0]  ack1, last1;
  logic        v1, ol1, err1;
  logic [7:0]  od1;
  logic [1:0]  id1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arb_burst_mux #(.DATA_W(8), .BURST_LEN(4)) u4 (
    .clk       (clk),
    .reset     (reset),
    .grant     (grant),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .err_grant (err_grant)
  );

  arb_burst_mux #(.DATA_W(8), .BURST_LEN(1)) u1 (
    .clk       (clk),
    .reset     (reset),
    .grant     (g1),
    .req_data  (d1),
    .req_ack   (ack1),
    .req_last  (last1),
    .out_valid (v1),
    .out_ready (r1),
    .out_data  (od1),
    .out_id    (id1),
    .out_last  (ol1),
    .err_grant (err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_id !== 2'd0 || req_ack !== 4'd0 ||
        req_last !== 4'd0 || out_data !== 8'd0 ||
        err_grant !== 1'b0) begin
      errors++;
      $display("FAIL reset_state v=%b l=%b id=%0d ack=%b rl=%b d=%h e=%b want all 0",
               out_valid, out_last, out_id, req_ack,
               req_last, out_data, err_grant);
    end
    checks++;
    if (v1 !== 1'b0 || err1 !== 1'b0 || ack1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_b1 v=%b e=%b ack=%b want 0",
               v1, err1, ack1);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    tick();
    grant = 4'b0100;
    out_ready = 1'b1;
    req_data[23:16] = 8'hA0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle valid=%b want 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      grant = 4'b0000;
      req_data[23:16] = 8'hA0 + 8'(k);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(k) ||
          out_id !== 2'd2 || req_ack !== 4'b0100) begin
        errors++;
        $display("FAIL single_beat%0d v=%b d=%h id=%0d ack=%b want 1 %h 2 0100",
                 k, out_valid, out_data, out_id, req_ack, 8'hA0 + 8'(k));
      end
      checks++;
      if (out_last !== (k == 3) ||
          req_last !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_last%0d last=%b rl=%b want %b", k,
                 out_last, req_last, (k == 3));
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_ack !== 4'd0) begin
      errors++;
      $display("FAIL single_end v=%b ack=%b want 0 0000",
               out_valid, req_ack);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    tick();
    grant = 4'b0001;
    out_ready = 1'b1;
    req_data[7:0] = 8'h10;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      tick();
      grant = 4'b0000;
      out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      req_data[7:0] = 8'h10 + 8'(hs);
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || req_ack !== 4'd0 ||
            out_id !== 2'd0 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall%0d v=%b ack=%b id=%0d last=%b want 1 0000 0 0",
                   c, out_valid, req_ack, out_id, out_last);
        end
      end
      if (c == 6) begin
        checks++;
        if (out_last !== 1'b1 || req_last !== 4'b0001) begin
          errors++;
          $display("FAIL bp_last last=%b rl=%b want 1 0001",
                   out_last, req_last);
        end
      end
      if (c == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_idle v=%b want 0", out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (out_data !== 8'h10 + 8'(hs) || req_ack !== 4'b0001) begin
          errors++;
          $display("FAIL bp_data%0d d=%h ack=%b want %h 0001",
                   hs, out_data, req_ack, 8'h10 + 8'(hs));
        end
        hs++;
      end
    end
    checks++;
    if (hs != 4) begin
      errors++;
      $display("FAIL bp_count hs=%0d want 4", hs);
    end
  endtask

  task automatic test_midburst();
    logic [3:0] gl [4];
    gl[0] = 4'b0001;
    gl[1] = 4'b0010;
    gl[2] = 4'b1000;
    gl[3] = 4'b0001;
    tick();
    grant = 4'b0100;
    out_ready = 1'b1;
    req_data[23:16] = 8'h55;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick();
      grant = gl[k];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 ||
          req_ack !== 4'b0100 || err_grant !== 1'b0) begin
        errors++;
        $display("FAIL mid_beat%0d v=%b id=%0d ack=%b e=%b want 1 2 0100 0",
                 k, out_valid, out_id, req_ack, err_grant);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_gap v=%b want 0", out_valid);
    end
    tick();
    grant = 4'b0000;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 ||
        req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL mid_next v=%b id=%0d ack=%b want 1 0 0001",
               out_valid, out_id, req_ack);
    end
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_done v=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    tick();
    grant = 4'b0110;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || err_grant !== 1'b1) begin
      errors++;
      $display("FAIL illegal v=%b e=%b want 0 1", out_valid, err_grant);
    end
    tick();
    grant = 4'b1000;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_nolock v=%b want 0", out_valid);
    end
    tick();
    grant = 4'b0000;
    req_data[31:24] = 8'h3C;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd3 ||
        out_data !== 8'h3C) begin
      errors++;
      $display("FAIL illegal_legal v=%b id=%0d d=%h want 1 3 3c",
               out_valid, out_id, out_data);
    end
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || err_grant !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky v=%b e=%b want 0 1",
               out_valid, err_grant);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    grant = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    grant = 4'b0000;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pre v=%b last=%b want 1 0",
               out_valid, out_last);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ack !== 4'd0 ||
        err_grant !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort v=%b ack=%b e=%b want 0 0000 0",
               out_valid, req_ack, err_grant);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_ack !== 4'd0) begin
      errors++;
      $display("FAIL rmid_idle v=%b ack=%b want 0 0000",
               out_valid, req_ack);
    end
  endtask

  task automatic test_burst1();
    tick();
    g1 = 4'b0001;
    d1 = 32'hD3C2B1A0;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL b1_idle0 v=%b want 0", v1);
    end
    tick();
    g1 = 4'b1000;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b1 || ol1 !== 1'b1 || id1 !== 2'd0 ||
        ack1 !== 4'b0001 || last1 !== 4'b0001 ||
        od1 !== 8'hA0) begin
      errors++;
      $display("FAIL b1_first v=%b l=%b id=%0d ack=%b rl=%b d=%h want 1 1 0 0001 0001 a0",
               v1, ol1, id1, ack1, last1, od1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL b1_gap v=%b want 0", v1);
    end
    tick();
    g1 = 4'b0000;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b1 || ol1 !== 1'b1 || id1 !== 2'd3 ||
        last1 !== 4'b1000 || od1 !== 8'hD3) begin
      errors++;
      $display("FAIL b1_second v=%b l=%b id=%0d rl=%b d=%h want 1 1 3 1000 d3",
               v1, ol1, id1, last1, od1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL b1_end v=%b e=%b want 0 0", v1, err1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_midburst();
    test_illegal();
    test_reset_mid();
    test_burst1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
